// File: rtl/ex_wb_pkg.sv
// Shared definitions for the execute/write-back stage: condition codes, flag
// bit positions and the branch-condition evaluator.
package ex_wb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  localparam logic [2:0] COND_BE  = 3'b000;
  localparam logic [2:0] COND_BLT = 3'b001;
  localparam logic [2:0] COND_BLE = 3'b010;
  localparam logic [2:0] COND_BNE = 3'b011;
  localparam logic [2:0] COND_B   = 3'b100;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Encodings above COND_B are reserved and never taken.
  function automatic logic cond_taken(input logic [2:0] cond, input logic s,
                                      input logic z, input logic v);
    logic lt;
    lt = s ^ v;
    case (cond)
      COND_BE:  return z;
      COND_BLT: return lt;
      COND_BLE: return z | lt;
      COND_BNE: return ~z;
      COND_B:   return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_wb_stage_result_fifo.sv
// In-order result FIFO with valid/ready on both sides; the head is read
// combinationally from storage, so there is no read latency.
module result_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             accept, drain;

  assign in_ready_o  = (count_q != FULL);
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = out_valid_o & out_ready_i;

  always_comb begin
    count_d = count_q;
    case ({accept, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is reset as well so stale heads never carry X downstream;
  // pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (accept) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (drain) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/write-back boundary: buffers results for the register file, holds
// the architectural flags and resolves conditional branches against them.
module ex_wb_stage
  import ex_wb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [3:0]        alu_flags_i,
  input  logic              alu_flag_wr_i,
  input  logic [REG_AW-1:0] in_rd_i,
  input  logic              in_reg_write_i,
  input  logic              in_branch_i,
  input  logic [2:0]        in_cond_i,
  input  logic [DATA_W-1:0] in_br_target_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              wb_reg_write_o,
  output logic [3:0]        flags_o,
  output logic              br_taken_o,
  output logic [DATA_W-1:0] br_target_o
);

  localparam int EW = DATA_W + REG_AW + 1;

  logic [EW-1:0]     fifo_out;
  logic              accept;
  logic [3:0]        flags_q, flags_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_target_q, br_target_d;

  result_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  ({alu_result_i, in_rd_i, in_reg_write_i}),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (fifo_out)
  );

  assign {wb_data_o, wb_rd_o, wb_reg_write_o} = fifo_out;
  assign accept = in_valid_i & in_ready_o;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  // Branches see flags_q (pre-update), so a flag-writing branch tests old flags.
  always_comb begin
    flags_d     = flags_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    if (accept) begin
      if (alu_flag_wr_i) flags_d = alu_flags_i;
      if (in_branch_i && cond_taken(in_cond_i, flags_q[FLAG_S], flags_q[FLAG_Z],
                                    flags_q[FLAG_V])) begin
        br_taken_d  = 1'b1;
        br_target_d = in_br_target_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flags_q     <= 4'b0000;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      flags_q     <= flags_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign flags_o     = flags_q;
  assign br_taken_o  = br_taken_q;
  assign br_target_o = br_target_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Scoreboard bench for ex_wb_stage: the driver pushes expected write-back
// entries on accept, a monitor pops and compares on every drain.
module tb_ex_wb_stage;
  import ex_wb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] alu_result_i = '0;
  logic [3:0]  alu_flags_i = '0;
  logic        alu_flag_wr_i = 1'b0;
  logic [2:0]  in_rd_i = '0;
  logic        in_reg_write_i = 1'b0;
  logic        in_branch_i = 1'b0;
  logic [2:0]  in_cond_i = '0;
  logic [15:0] in_br_target_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] wb_data_o;
  logic [2:0]  wb_rd_o;
  logic        wb_reg_write_o;
  logic [3:0]  flags_o;
  logic        br_taken_o;
  logic [15:0] br_target_o;

  int checks = 0;
  int failures = 0;
  int last_wait;
  logic [19:0] exp_q[$];
  logic [15:0] exp_target = '0;

  always #5 clk_i = ~clk_i;

  ex_wb_stage #(.DATA_W(16), .REG_AW(3), .BUF_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i),
    .alu_flag_wr_i(alu_flag_wr_i), .in_rd_i(in_rd_i),
    .in_reg_write_i(in_reg_write_i), .in_branch_i(in_branch_i),
    .in_cond_i(in_cond_i), .in_br_target_i(in_br_target_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_reg_write_o(wb_reg_write_o),
    .flags_o(flags_o), .br_taken_o(br_taken_o), .br_target_o(br_target_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every drain must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) check("wb_unexpected", {12'h0, wb_data_o, wb_rd_o, wb_reg_write_o}, 32'hFFFF_FFFF);
        else check("wb_entry", {12'h0, wb_data_o, wb_rd_o, wb_reg_write_o}, {12'h0, exp_q.pop_front()});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with inputs still driven.
  task automatic send(input logic [15:0] data, input logic [2:0] rd, input logic rw,
                      input logic fwr, input logic [3:0] fl, input logic br,
                      input logic [2:0] cond, input logic [15:0] tgt);
    int waited;
    waited = 0;
    in_valid_i = 1'b1; alu_result_i = data; in_rd_i = rd; in_reg_write_i = rw;
    alu_flag_wr_i = fwr; alu_flags_i = fl; in_branch_i = br; in_cond_i = cond;
    in_br_target_i = tgt;
    @(negedge clk_i);
    while (!in_ready_o && waited < 20) begin
      waited++;
      @(negedge clk_i);
    end
    last_wait = waited;
    if (!in_ready_o) begin
      check("send_timeout", 32'(in_ready_o), 32'd1);
      in_valid_i = 1'b0;
    end else begin
      exp_q.push_back({data, rd, rw});
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    in_valid_i = 1'b0; alu_flag_wr_i = 1'b0; in_branch_i = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] fl);
    send(16'h0, 3'd0, 1'b0, 1'b1, fl, 1'b0, 3'd0, 16'h0);
    idle();
    @(negedge clk_i);
    check("flags_commit", 32'(flags_o), 32'(fl));
    @(posedge clk_i); #1;
  endtask

  task automatic branch(input string name, input logic [2:0] cond, input logic [15:0] tgt,
                        input logic fwr, input logic [3:0] fl, input logic exp_taken);
    send(tgt, 3'd0, 1'b0, fwr, fl, 1'b1, cond, tgt);
    idle();
    if (exp_taken) exp_target = tgt;
    @(negedge clk_i);
    check({name, "_taken"}, 32'(br_taken_o), 32'(exp_taken));
    check({name, "_target"}, 32'(br_target_o), 32'(exp_target));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check({name, "_pulse_end"}, 32'(br_taken_o), 32'd0);
    @(posedge clk_i); #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_flags", 32'(flags_o), 32'd0);
    check("rst_br_taken", 32'(br_taken_o), 32'd0);
    check("rst_br_target", 32'(br_target_o), 32'd0);
    @(posedge clk_i); #1;

    // Back-pressure: fill both entries, then release
    out_ready_i = 1'b0;
    send(16'h0005, 3'd1, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
    idle();
    @(negedge clk_i);
    check("bp_valid_latency", 32'(out_valid_o), 32'd1);
    @(posedge clk_i); #1;
    send(16'h00FF, 3'd2, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
    idle();
    @(negedge clk_i);
    check("bp_full_in_ready", 32'(in_ready_o), 32'd0);
    check("bp_head_data", 32'(wb_data_o), 32'h0005);
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    wait_drain("bp_drain");

    // Streaming: eight back-to-back accepts with count held at one
    for (int i = 0; i < 8; i++) begin
      send(16'h1000 + 16'(i * 17), 3'(i), 1'(i % 2), 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
      check("stream_no_stall", 32'(last_wait), 32'd0);
    end
    idle();
    wait_drain("stream_drain");

    // Flag then branch
    set_flags(4'b0100);
    branch("be_after_sub", COND_BE, 16'h0040, 1'b0, 4'h0, 1'b1);

    // Signed conditions, S=1 V=0
    set_flags(4'b1000);
    branch("blt_s1v0", COND_BLT, 16'h0100, 1'b0, 4'h0, 1'b1);
    branch("ble_s1v0", COND_BLE, 16'h0104, 1'b0, 4'h0, 1'b1);
    branch("bne_s1v0", COND_BNE, 16'h0108, 1'b0, 4'h0, 1'b1);
    branch("be_s1v0",  COND_BE,  16'h010C, 1'b0, 4'h0, 1'b0);

    // S=1 V=1: less-than is false
    set_flags(4'b1001);
    branch("blt_s1v1", COND_BLT, 16'h0200, 1'b0, 4'h0, 1'b0);
    branch("ble_s1v1", COND_BLE, 16'h0202, 1'b0, 4'h0, 1'b0);
    branch("b_always", COND_B,   16'h0204, 1'b0, 4'h0, 1'b1);
    branch("cond_101", 3'b101,   16'h0208, 1'b0, 4'h0, 1'b0);

    // Flag-writing branch evaluates on the old flags
    set_flags(4'b0000);
    branch("be_flag_wr", COND_BE, 16'h0300, 1'b1, 4'b0100, 1'b0);
    @(negedge clk_i);
    check("be_flag_wr_flags", 32'(flags_o), 32'b0100);
    @(posedge clk_i); #1;
    wait_drain("branch_drain");

    // Reset mid-stream with a full FIFO
    out_ready_i = 1'b0;
    send(16'hAAAA, 3'd3, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
    send(16'hBBBB, 3'd4, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
    idle();
    @(negedge clk_i);
    check("mid_full", 32'(in_ready_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    exp_q.delete();
    exp_target = '0;
    @(negedge clk_i);
    check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready_o), 32'd1);
    check("mid_rst_flags", 32'(flags_o), 32'd0);
    check("mid_rst_br_taken", 32'(br_taken_o), 32'd0);
    check("mid_rst_br_target", 32'(br_target_o), 32'd0);
    @(posedge clk_i); #1;

    // FIFO works cleanly after reset
    out_ready_i = 1'b1;
    send(16'h1234, 3'd7, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
    send(16'h5678, 3'd6, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 16'h0);
    idle();
    wait_drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
